// File: rtl/gray_pkg.sv
// gray_pkg: shared types and constants for the gray/binary stream converter.
//   gray_mode_t : runtime reduction mode selected at frame start
//   state_t     : frame sequencer states
//   LUMA_*      : fixed-point BT.601-style luma weights (sum 256) and rounding
package gray_pkg;

    typedef enum logic [1:0] {
        GRAY_LUMA   = 2'd0,
        GRAY_MAX    = 2'd1,
        GRAY_SEL    = 2'd2,
        GRAY_THRESH = 2'd3
    } gray_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FLAG  = 2'd3
    } state_t;

    localparam int LUMA_W_R   = 77;
    localparam int LUMA_W_G   = 150;
    localparam int LUMA_W_B   = 29;
    localparam int LUMA_RND   = 128;
    localparam int LUMA_SHIFT = 8;

endpackage

// File: rtl/convert_gray_stream_if.sv
// convert_gray_stream_if: start/config, image-SRAM read and conversion-SRAM
// write signals of the gray converter.
//   slave  : converter side (takes start/config and read data, drives the rest)
//   master : controller / memory side
interface convert_gray_stream_if #(
    parameter int X_MAX       = 200,
    parameter int Y_MAX       = 200,
    parameter int PIXEL_DEPTH = 8,
    parameter int CHANNELS    = 3
);
    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(Y_MAX);

    logic                            new_trans;
    logic [1:0]                      mode;
    logic [1:0]                      chan_sel;
    logic [PIXEL_DEPTH-1:0]          threshold;
    logic [XW-1:0]                   max_x;
    logic [YW-1:0]                   max_y;
    logic                            busy;
    logic                            bw_done;
    logic [XW:0]                     x_addr_img;
    logic [YW:0]                     y_addr_img;
    logic                            ren_img;
    logic [CHANNELS*PIXEL_DEPTH-1:0] rdat_img;
    logic [XW:0]                     x_addr_conv;
    logic [YW:0]                     y_addr_conv;
    logic                            wen_conv;
    logic [PIXEL_DEPTH-1:0]          wdat_conv;

    modport slave (
        input  new_trans, mode, chan_sel, threshold, max_x, max_y, rdat_img,
        output busy, bw_done, x_addr_img, y_addr_img, ren_img,
               x_addr_conv, y_addr_conv, wen_conv, wdat_conv
    );

    modport master (
        output new_trans, mode, chan_sel, threshold, max_x, max_y, rdat_img,
        input  busy, bw_done, x_addr_img, y_addr_img, ren_img,
               x_addr_conv, y_addr_conv, wen_conv, wdat_conv
    );

endinterface

// File: rtl/gray_pixel_core.sv
// gray_pixel_core: combinational reduction of one packed pixel to a single
// PIXEL_DEPTH value.
//   mode      : reduction mode
//   chan_sel  : channel index used by GRAY_SEL
//   threshold : cut level used by GRAY_THRESH
//   pix       : CHANNELS packed samples, channel 0 in the LSBs
//   gray      : reduced value
module gray_pixel_core
    import gray_pkg::*;
#(
    parameter int PIXEL_DEPTH = 8,
    parameter int CHANNELS    = 3
) (
    input  gray_mode_t                      mode,
    input  logic [1:0]                      chan_sel,
    input  logic [PIXEL_DEPTH-1:0]          threshold,
    input  logic [CHANNELS*PIXEL_DEPTH-1:0] pix,
    output logic [PIXEL_DEPTH-1:0]          gray
);
    localparam int PD = PIXEL_DEPTH;
    localparam int LW = PIXEL_DEPTH + 9;
    localparam logic [PD-1:0] ONES = '1;

    // Zero-extend to four channels so every channel index is in range
    // regardless of CHANNELS.
    logic [4*PD-1:0] pix_ext;
    logic [PD-1:0]   c [4];
    logic [LW-1:0]   acc;
    logic [PD-1:0]   luma;
    logic [PD-1:0]   max_v;
    logic [PD-1:0]   sel_v;

    function automatic logic [PD-1:0] round_sat(input logic [LW-1:0] a);
        logic [LW-1:0] q;
        q = a >> LUMA_SHIFT;
        if (q > LW'(ONES))
            return ONES;
        return q[PD-1:0];
    endfunction

    assign pix_ext = (4*PD)'(pix);

    always_comb begin
        for (int i = 0; i < 4; i++)
            c[i] = pix_ext[i*PD +: PD];
    end

    always_comb begin
        acc = LW'(LUMA_W_R) * LW'(c[0]) + LW'(LUMA_W_G) * LW'(c[1])
            + LW'(LUMA_W_B) * LW'(c[2]) + LW'(LUMA_RND);
        if (CHANNELS >= 3)
            luma = round_sat(acc);
        else
            luma = c[0];
    end

    always_comb begin
        max_v = c[0];
        for (int i = 1; i < CHANNELS; i++)
            if (c[i] > max_v)
                max_v = c[i];
    end

    // A single-channel image passes through unchanged for any index.
    always_comb begin
        sel_v = '0;
        if (CHANNELS == 1)
            sel_v = c[0];
        else if (int'(chan_sel) < CHANNELS)
            sel_v = c[chan_sel];
    end

    always_comb begin
        gray = luma;
        case (mode)
            GRAY_LUMA:   gray = luma;
            GRAY_MAX:    gray = max_v;
            GRAY_SEL:    gray = sel_v;
            GRAY_THRESH: gray = (luma >= threshold) ? ONES : '0;
            default:     gray = luma;
        endcase
    end

endmodule

// File: rtl/convert_gray_stream.sv
// convert_gray_stream: streams a (max_x+1) x (max_y+1) frame out of the image
// SRAM in raster order, reduces each pixel and writes it to the same (x,y) in
// the conversion SRAM at one pixel per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : start/config, image read port, conversion write port, busy/bw_done
module convert_gray_stream
    import gray_pkg::*;
#(
    parameter int X_MAX       = 200,
    parameter int Y_MAX       = 200,
    parameter int PIXEL_DEPTH = 8,
    parameter int CHANNELS    = 3
) (
    input logic                  clk,
    input logic                  rst,
    convert_gray_stream_if.slave bus
);
    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(Y_MAX);
    localparam int PD = PIXEL_DEPTH;

    state_t           state, state_nx;
    gray_mode_t       mode_q;
    logic [1:0]       sel_q;
    logic [PD-1:0]    thr_q;
    logic [XW-1:0]    max_x_q, x_cnt;
    logic [YW-1:0]    max_y_q, y_cnt;
    logic             last_rd;

    logic             ren_p0, vld_p1, vld_p2;
    logic [XW:0]      x_p0, x_p1, x_p2;
    logic [YW:0]      y_p0, y_p1, y_p2;
    logic [PD-1:0]    dat_p2;
    logic [PD-1:0]    gray;

    assign last_rd = (x_cnt == max_x_q) && (y_cnt == max_y_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // DRAIN ends once stages 0 and 1 are empty: the last write is then
    // leaving stage 2 in this cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.new_trans) state_nx = READ;
            READ:    if (last_rd) state_nx = DRAIN;
            DRAIN:   if (!ren_p0 && !vld_p1) state_nx = FLAG;
            FLAG:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Frame configuration is frozen at start; counters walk the raster.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= GRAY_LUMA;
            sel_q   <= '0;
            thr_q   <= '0;
            max_x_q <= '0;
            max_y_q <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
        end else begin
            if (state == IDLE && bus.new_trans) begin
                mode_q  <= gray_mode_t'(bus.mode);
                sel_q   <= bus.chan_sel;
                thr_q   <= bus.threshold;
                max_x_q <= bus.max_x;
                max_y_q <= bus.max_y;
            end
            if (state == READ) begin
                if (x_cnt == max_x_q) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end else begin
                x_cnt <= '0;
                y_cnt <= '0;
            end
        end
    end

    // Stage 0: issue read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ren_p0 <= 1'b0;
            x_p0   <= '0;
            y_p0   <= '0;
        end else begin
            ren_p0 <= (state == READ);
            x_p0   <= (state == READ) ? {1'b0, x_cnt} : '0;
            y_p0   <= (state == READ) ? {1'b0, y_cnt} : '0;
        end
    end

    // Stage 1: address waits for the SRAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            x_p1   <= '0;
            y_p1   <= '0;
        end else begin
            vld_p1 <= ren_p0;
            x_p1   <= x_p0;
            y_p1   <= y_p0;
        end
    end

    gray_pixel_core #(
        .PIXEL_DEPTH (PIXEL_DEPTH),
        .CHANNELS    (CHANNELS)
    ) u_core (
        .mode      (mode_q),
        .chan_sel  (sel_q),
        .threshold (thr_q),
        .pix       (bus.rdat_img),
        .gray      (gray)
    );

    // Stage 2: registered write; data holds between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            x_p2   <= '0;
            y_p2   <= '0;
            dat_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            x_p2   <= vld_p1 ? x_p1 : '0;
            y_p2   <= vld_p1 ? y_p1 : '0;
            if (vld_p1)
                dat_p2 <= gray;
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.bw_done     = (state == FLAG);
    assign bus.ren_img     = ren_p0;
    assign bus.x_addr_img  = x_p0;
    assign bus.y_addr_img  = y_p0;
    assign bus.wen_conv    = vld_p2;
    assign bus.x_addr_conv = x_p2;
    assign bus.y_addr_conv = y_p2;
    assign bus.wdat_conv   = dat_p2;

endmodule

// File: tb/tb_convert_gray_stream.sv
// tb_convert_gray_stream: directed bench for convert_gray_stream with a
// behavioural image SRAM (1-cycle read) and a write recorder.
module tb_convert_gray_stream;
    import gray_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    convert_gray_stream_if #(.X_MAX(200), .Y_MAX(200), .PIXEL_DEPTH(8), .CHANNELS(3)) bus ();

    convert_gray_stream #(.X_MAX(200), .Y_MAX(200), .PIXEL_DEPTH(8), .CHANNELS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] img [0:15][0:15];

    always @(posedge clk)
        if (bus.ren_img)
            bus.rdat_img <= img[bus.y_addr_img[3:0]][bus.x_addr_img[3:0]];

    typedef struct { int c; int x; int y; int d; } wr_t;
    wr_t wq[$];
    int  ren_cnt = 0;

    always @(negedge clk) begin
        if (bus.wen_conv)
            wq.push_back('{cyc, int'(bus.x_addr_conv), int'(bus.y_addr_conv), int'(bus.wdat_conv)});
        if (bus.ren_img)
            ren_cnt <= ren_cnt + 1;
    end

    typedef struct { int m; int s; int th; int c0; int c1; int c2; int exp; } vec_t;
    vec_t vecs[12];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] pk(input int c0, input int c1, input int c2);
        return {c2[7:0], c1[7:0], c0[7:0]};
    endfunction

    task automatic start(input int m, input int s, input int th, input int mx, input int my,
                         output int t);
        @(negedge clk);
        bus.mode      = m[1:0];
        bus.chan_sel  = s[1:0];
        bus.threshold = th[7:0];
        bus.max_x     = mx[7:0];
        bus.max_y     = my[7:0];
        bus.new_trans = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        bus.new_trans = 1'b0;
    endtask

    task automatic wait_bw(input int limit, output int bwc);
        bwc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.bw_done) begin
                bwc = cyc;
                break;
            end
        end
        if (bwc < 0)
            chk("bw_timeout", 0, 1);
        else
            chk("busy_in_flag", int'(bus.busy), 1);
    endtask

    // Checks count, timing, raster addresses and data of one frame's writes.
    task automatic verify(input string nm, input int t, input int mx, input int my,
                          input int base, input int rbase, input int ed[16]);
        int n, bwc;
        n = (mx + 1) * (my + 1);
        wait_bw(100, bwc);
        chk({nm, "_bw_cyc"}, bwc, t + n + 3);
        chk({nm, "_wr_cnt"}, wq.size() - base, n);
        chk({nm, "_rd_cnt"}, ren_cnt - rbase, n);
        for (int k = 0; k < n && base + k < wq.size(); k++) begin
            chk($sformatf("%s_wr%0d_cyc", nm, k), wq[base+k].c, t + 3 + k);
            chk($sformatf("%s_wr%0d_xy", nm, k), wq[base+k].x * 256 + wq[base+k].y,
                (k % (mx + 1)) * 256 + k / (mx + 1));
            chk($sformatf("%s_wr%0d_dat", nm, k), wq[base+k].d, ed[k]);
        end
    endtask

    task automatic load_plan_img();
        img[0][0] = pk(255, 255, 255);
        img[0][1] = pk(0, 0, 0);
        img[1][0] = pk(255, 0, 0);
        img[1][1] = pk(0, 255, 0);
    endtask

    initial begin
        int t, base, rbase, n;
        int ed[16];

        vecs[0]  = '{0, 0, 0,   255, 255, 255, 255};
        vecs[1]  = '{0, 0, 0,   0,   0,   0,   0};
        vecs[2]  = '{0, 0, 0,   255, 0,   0,   77};
        vecs[3]  = '{0, 0, 0,   0,   255, 0,   149};
        vecs[4]  = '{0, 0, 0,   10,  200, 30,  124};
        vecs[5]  = '{1, 0, 0,   10,  200, 30,  200};
        vecs[6]  = '{1, 0, 0,   250, 3,   251, 251};
        vecs[7]  = '{2, 2, 0,   10,  200, 30,  30};
        vecs[8]  = '{2, 3, 0,   10,  200, 30,  0};
        vecs[9]  = '{2, 0, 0,   10,  200, 30,  10};
        vecs[10] = '{3, 0, 128, 127, 127, 127, 0};
        vecs[11] = '{3, 0, 128, 128, 128, 128, 255};

        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                img[y][x] = '0;
        bus.new_trans = 1'b0;
        bus.mode      = '0;
        bus.chan_sel  = '0;
        bus.threshold = '0;
        bus.max_x     = '0;
        bus.max_y     = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ren_wen_done", int'({bus.ren_img, bus.wen_conv, bus.bw_done}), 0);
        chk("rst_addr", int'({bus.x_addr_img, bus.y_addr_img, bus.x_addr_conv, bus.y_addr_conv}), 0);
        chk("rst_wdat", int'(bus.wdat_conv), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single-pixel frames from the vector table
        for (int i = 0; i < 12; i++) begin
            img[0][0] = pk(vecs[i].c0, vecs[i].c1, vecs[i].c2);
            start(vecs[i].m, vecs[i].s, vecs[i].th, 0, 0, t);
            base  = wq.size();
            rbase = ren_cnt;
            ed[0] = vecs[i].exp;
            verify($sformatf("vec%0d", i), t, 0, 0, base, rbase, ed);
        end

        // 2x2 luma frame, then a back-to-back max-channel frame
        load_plan_img();
        start(0, 0, 0, 1, 1, t);
        base = wq.size(); rbase = ren_cnt;
        ed[0] = 255; ed[1] = 0; ed[2] = 77; ed[3] = 149;
        verify("luma2x2", t, 1, 1, base, rbase, ed);
        start(1, 0, 0, 1, 1, t);
        base = wq.size(); rbase = ren_cnt;
        ed[0] = 255; ed[1] = 0; ed[2] = 255; ed[3] = 255;
        verify("b2b", t, 1, 1, base, rbase, ed);

        // 4x3 channel-select frame with a second start and config change mid-frame
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) begin
                img[y][x] = pk(16 * y + x + 1, 200, 5);
                ed[y*4 + x] = 16 * y + x + 1;
            end
        start(2, 0, 0, 3, 2, t);
        base = wq.size(); rbase = ren_cnt;
        repeat (3) @(negedge clk);
        bus.new_trans = 1'b1;
        bus.mode      = 2'd1;
        bus.chan_sel  = 2'd1;
        bus.max_x     = 8'd1;
        bus.max_y     = 8'd0;
        @(negedge clk);
        bus.new_trans = 1'b0;
        verify("midframe", t, 3, 2, base, rbase, ed);

        // reset at the 5th read of a 4x4 frame
        start(0, 0, 0, 3, 3, t);
        n = 0;
        for (int i = 0; i < 30 && n < 5; i++) begin
            @(negedge clk);
            if (bus.ren_img) n++;
        end
        chk("rst_reads_seen", n, 5);
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", int'({bus.busy, bus.bw_done, bus.ren_img, bus.wen_conv}), 0);
        chk("midrst_addr", int'({bus.x_addr_img, bus.y_addr_img, bus.x_addr_conv, bus.y_addr_conv}), 0);
        chk("midrst_wdat", int'(bus.wdat_conv), 0);
        base = wq.size();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ren_img || bus.wen_conv || bus.busy) n++;
        end
        chk("postrst_idle_cycles", n, 0);
        chk("postrst_writes", wq.size() - base, 0);

        // fresh frame after reset starts at (0,0)
        load_plan_img();
        start(0, 0, 0, 1, 1, t);
        base = wq.size(); rbase = ren_cnt;
        ed[0] = 255; ed[1] = 0; ed[2] = 77; ed[3] = 149;
        verify("restart", t, 1, 1, base, rbase, ed);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/convert_gray_stream.md
Name: convert_gray_stream

Overview:
- Parametrised successor to the single-channel black/white converter.
- Streams a (max_x+1) x (max_y+1) frame from the image SRAM in raster order and reduces CHANNELS packed colour samples per pixel to one PIXEL_DEPTH gray/binary value.
- Writes each result to the same (x,y) address in the conversion SRAM.
- Runtime-selectable reduction mode, optional thresholding, and a one-pixel-per-cycle pipeline; sits ahead of the blur/FAST stages.

Parameters:
- X_MAX, 200, maximum frame width supported.
- Y_MAX, 200, maximum frame height supported.
- PIXEL_DEPTH, 8, bits per channel sample and per output pixel.
- CHANNELS, 3, channels packed per image word; channel 0 in LSBs; channels 0/1/2 = R/G/B. Legal range 1..4.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- new_trans  in  1  start pulse; sampled only in IDLE
- mode  in  2  0=luma, 1=max channel, 2=channel select, 3=luma threshold; latched at start
- chan_sel  in  2  channel index for mode 2; latched at start
- threshold  in  PIXEL_DEPTH  mode 3 cut level; latched at start
- max_x  in  $clog2(X_MAX)  last column index (inclusive)
- max_y  in  $clog2(Y_MAX)  last row index (inclusive)
- busy  out  1  high from the cycle after accepted start through the FLAG cycle
- bw_done  out  1  one-cycle completion pulse
- x_addr_img, y_addr_img  out  $clog2(X_MAX)+1, $clog2(Y_MAX)+1  read address
- ren_img  out  1  read enable; SRAM returns data exactly 1 cycle later
- rdat_img  in  CHANNELS*PIXEL_DEPTH  packed pixel
- x_addr_conv, y_addr_conv  out  same widths as the read address  write address
- wen_conv  out  1  write strobe
- wdat_conv  out  PIXEL_DEPTH  output pixel

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters and latches 0. A reset mid-frame abandons the frame immediately, and no further writes occur.
- FSM states:
  - IDLE: on new_trans, latch mode/chan_sel/threshold/max_x/max_y, go to READ.
  - READ: issue one read per cycle. After the read of (max_x,max_y) is issued, go to DRAIN.
  - DRAIN: wait until the last write has been issued, then go to FLAG.
  - FLAG: bw_done=1 for one cycle, then IDLE.
- new_trans outside IDLE is ignored. Input changes to mode/max_x/max_y mid-frame have no effect.
- Scan order: x increments 0..max_x. At x=max_x, x wraps to 0 and y increments. Read stops after (max_x,max_y). max_x=max_y=0 is a legal single-pixel frame.
- Pipeline, with T = the cycle new_trans is sampled and N=(max_x+1)(max_y+1):
  - Stage 0: ren_img and address at T+1+k for pixel k.
  - Stage 1: rdat_img is captured with its address delayed by one cycle.
  - Stage 2: wen_conv, wdat_conv and the write address are registered outputs at T+3+k.
  - The last write is at T+N+2 and bw_done at T+N+3.
- Timing of strobes: ren_img and wen_conv are never high for more than N cycles per frame. The write address always equals the read address of the same pixel, two cycles earlier.
- Mode 0 (luma): (77*c0 + 150*c1 + 29*c2 + 128) >> 8. Intermediate width is PIXEL_DEPTH+9 bits. The result saturates at 2^PIXEL_DEPTH-1.
- Mode 1: maximum of all CHANNELS samples.
- Mode 2: sample chan_sel. If chan_sel >= CHANNELS, the result is 0.
- Mode 3: luma >= threshold gives all-ones, otherwise 0.
- CHANNELS<3: modes 0 and 3 use channel 0 as luma. CHANNELS=1 makes all modes except 3 a passthrough.
- wdat_conv holds its last value while wen_conv=0. Addresses return to 0 in IDLE.

Decomposition:
- Package gray_pkg holds:
  - gray_mode_t enum (GRAY_LUMA, GRAY_MAX, GRAY_SEL, GRAY_THRESH);
  - the luma weight constants 77/150/29 and the rounding constant 128;
  - the state enum (IDLE, READ, DRAIN, FLAG).
- Sub-module gray_pixel_core (parameters PIXEL_DEPTH, CHANNELS): combinational channel reduction plus mode mux. The top holds the FSM, raster counters and pipeline valid/address registers.

Test Plan:
- CHANNELS=3, mode 0, max_x=1, max_y=1, pixels (255,255,255),(0,0,0),(255,0,0),(0,255,0) -> writes 255,0,77,149 at (0,0),(1,0),(0,1),(1,1); bw_done exactly at T+7.
- Mode 1, pixel (10,200,30) -> 200. Mode 2 chan_sel=2 -> 30. Mode 2 chan_sel=3 -> 0.
- Mode 3, threshold=128: luma 127 -> 0x00, luma 128 -> 0xFF; single-pixel frame (max_x=max_y=0) -> one write, bw_done at T+4.
- Frame 4x3 started, new_trans pulsed again mid-frame plus mode changed -> ignored; exactly 12 writes in raster order with the original mode.
- rst asserted at 5th read of a 4x4 frame -> all outputs 0 that same cycle; no writes after; fresh new_trans restarts at (0,0).
- Back-to-back frames: new_trans asserted in the cycle after bw_done -> second frame starts normally, with no stale write from the first.
